ula_arbitro: RTL



---
 rtl/ula_arbitro.sv | 118 +++++++++++
 1 files changed

// File: rtl/ula_arbitro.sv
// ula_arbitro: round-robin sharing of one ULA between two requesters with valid/ready results
module ula_arbitro #(
  parameter int LARGURA = 16,
  parameter int LAT     = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               req0,
  input  logic [LARGURA-1:0] a0,
  input  logic [LARGURA-1:0] b0,
  input  logic               h0,
  output logic               ack0,
  output logic               rvalid0,
  input  logic               rready0,
  input  logic               req1,
  input  logic [LARGURA-1:0] a1,
  input  logic [LARGURA-1:0] b1,
  input  logic               h1,
  output logic               ack1,
  output logic               rvalid1,
  input  logic               rready1,
  output logic [LARGURA-1:0] resultado_out,
  output logic [LARGURA-1:0] M1,
  output logic [LARGURA-1:0] M2,
  output logic               H,
  input  logic [LARGURA-1:0] resultado
);
  typedef enum logic [1:0] {LIVRE, EXEC, RESP} estado_t;
  estado_t estado_q, estado_d;
  logic ptr_q, ptr_d, idx_q, idx_d, h_q, h_d;
  logic ack0_q, ack0_d, ack1_q, ack1_d, rv0_q, rv0_d, rv1_q, rv1_d;
  logic [LARGURA-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0] cnt_q, cnt_d;
  logic win;
  // requester 1 wins when it is alone, or when both ask and the pointer names it
  assign win = req1 & (~req0 | ptr_q);
  // next-state: grant in LIVRE, count ULA latency in EXEC, hold response in RESP
  always_comb begin
    estado_d = estado_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    a_d = a_q;
    b_d = b_q;
    h_d = h_q;
    res_d = res_q;
    cnt_d = cnt_q;
    rv0_d = rv0_q;
    rv1_d = rv1_q;
    ack0_d = 1'b0;
    ack1_d = 1'b0;
    case (estado_q)
      LIVRE: if (req0 | req1) begin
        idx_d = win;
        a_d = win ? a1 : a0;
        b_d = win ? b1 : b0;
        h_d = win ? h1 : h0;
        ack0_d = ~win;
        ack1_d = win;
        ptr_d = ~win;
        cnt_d = '0;
        estado_d = EXEC;
      end
      EXEC: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(LAT - 1)) begin
          res_d = resultado;
          rv0_d = ~idx_q;
          rv1_d = idx_q;
          estado_d = RESP;
        end
      end
      RESP: if (idx_q ? rready1 : rready0) begin
        rv0_d = 1'b0;
        rv1_d = 1'b0;
        estado_d = LIVRE;
      end
      default: estado_d = LIVRE;
    endcase
  end
  // state and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= LIVRE;
      ptr_q <= 1'b0;
      idx_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      h_q <= 1'b0;
      res_q <= '0;
      cnt_q <= '0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      a_q <= a_d;
      b_q <= b_d;
      h_q <= h_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
      rv0_q <= rv0_d;
      rv1_q <= rv1_d;
    end
  end
  assign ack0 = ack0_q;
  assign ack1 = ack1_q;
  assign rvalid0 = rv0_q;
  assign rvalid1 = rv1_q;
  assign M1 = (estado_q == LIVRE) ? '0 : a_q;
  assign M2 = (estado_q == LIVRE) ? '0 : b_q;
  assign H = (estado_q == LIVRE) ? 1'b0 : h_q;
  assign resultado_out = (estado_q == RESP) ? res_q : '0;
endmodule
